dpram_copy_engine: RTL

- Initiator for the DualPortRAM block. Drives port A as a read-only master and port B as a write-only master to copy a block of `len` words from `srcAddr` to `dstAddr` inside one RAM.
- Steady state moves one word per clock. Handles overlapping regions like memmove.
- Sits between a control/CSR block and the RAM, replacing software word-by-word copies.

---
 rtl/dpram_copy_engine.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dpram_copy_engine.sv
// rtl/dpram_copy_engine.sv - memmove-style block copy engine driving a dual-port RAM
// Port A only reads and port B only writes. The copy direction is chosen so that a source word is never overwritten before it has been read.
module dpram_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          start,
  input  logic [AW-1:0] srcAddr,
  input  logic [AW-1:0] dstAddr,
  input  logic [AW:0]   len,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          aEn,
  output logic          aWrite,
  output logic [AW-1:0] aAddr,
  output logic [DW-1:0] aWriteData,
  input  logic [DW-1:0] aReadData,
  output logic          bEn,
  output logic          bWrite,
  output logic [AW-1:0] bAddr,
  output logic [DW-1:0] bWriteData
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  localparam logic [AW-1:0] L_ONE_A = AW'(1);
  localparam logic [AW:0]   L_ONE_L = (AW+1)'(1);

  state_t        r_state;
  state_t        w_next;
  logic [AW:0]   r_len;
  logic [AW:0]   r_ridx;
  logic [AW-1:0] r_d;
  logic          r_desc;
  logic          r_aEn;
  logic [AW-1:0] r_aAddr;
  logic          r_rdValid;
  logic [AW-1:0] r_bAddr;
  logic          r_aborted;

  logic [AW-1:0] w_d;
  logic          w_desc;
  logic [AW-1:0] w_first;
  logic          w_last;

  assign w_d     = dstAddr - srcAddr;
  assign w_desc  = (w_d != '0) && ({1'b0, w_d} < len);
  assign w_first = w_desc ? (srcAddr + len[AW-1:0] - L_ONE_A) : srcAddr;
  assign w_last  = (r_ridx == (r_len - L_ONE_L));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_FIN : S_RUN;
      S_RUN:   if (abort || w_last) w_next = abort ? S_FIN : S_DRAIN;
      S_DRAIN: w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The write address tracks the read address one edge later, offset by the copy distance.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_len     <= '0;
      r_ridx    <= '0;
      r_d       <= '0;
      r_desc    <= 1'b0;
      r_aEn     <= 1'b0;
      r_aAddr   <= '0;
      r_rdValid <= 1'b0;
      r_bAddr   <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_rdValid <= r_aEn && !abort;
      r_bAddr   <= r_aAddr + r_d;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len     <= len;
            r_d       <= w_d;
            r_desc    <= w_desc;
            r_aborted <= 1'b0;
            r_ridx    <= '0;
            r_aAddr   <= w_first;
            r_aEn     <= (len != '0);
          end
        end
        S_RUN: begin
          if (abort) begin
            r_aEn     <= 1'b0;
            r_aborted <= 1'b1;
          end else if (w_last) begin
            r_aEn <= 1'b0;
          end else begin
            r_ridx  <= r_ridx + L_ONE_L;
            r_aAddr <= r_desc ? (r_aAddr - L_ONE_A) : (r_aAddr + L_ONE_A);
          end
        end
        S_DRAIN: if (abort) r_aborted <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done       = (r_state == S_FIN);
  assign aborted    = done && r_aborted;
  assign aEn        = r_aEn;
  assign aWrite     = 1'b0;
  assign aAddr      = r_aAddr;
  assign aWriteData = '0;
  assign bEn        = r_rdValid;
  assign bWrite     = r_rdValid;
  assign bAddr      = r_bAddr;
  assign bWriteData = r_rdValid ? aReadData : '0;

endmodule
